// File: rtl/efuse_seq_ctrl_if.sv
// efuse_seq_ctrl_if: request, timing, eFuse mux and shadow-write signals of the eFuse sequencer
interface efuse_seq_ctrl_if #(parameter int CW = 8);
  logic          rd_start;
  logic          wr_req;
  logic [7:0]    wr_addr;
  logic [CW-1:0] t_setup;
  logic [CW-1:0] t_rd;
  logic [CW-1:0] t_pgm;
  logic [CW-1:0] t_hold;
  logic          efuse_pgmen;
  logic          efuse_rden;
  logic          efuse_aen;
  logic [7:0]    efuse_addr;
  logic          busy_read;
  logic          busy_write;
  logic [7:0]    read_rdata;
  logic          sh_we;
  logic [7:0]    sh_addr;
  logic [7:0]    sh_wdata;
  logic          rd_done;
  logic          wr_done;
  logic          wr_err;
  logic          req_drop;
  modport master (
    input  rd_start, wr_req, wr_addr, t_setup, t_rd, t_pgm, t_hold, read_rdata,
    output efuse_pgmen, efuse_rden, efuse_aen, efuse_addr, busy_read, busy_write,
           sh_we, sh_addr, sh_wdata, rd_done, wr_done, wr_err, req_drop
  );
  modport slave (
    output rd_start, wr_req, wr_addr, t_setup, t_rd, t_pgm, t_hold, read_rdata,
    input  efuse_pgmen, efuse_rden, efuse_aen, efuse_addr, busy_read, busy_write,
           sh_we, sh_addr, sh_wdata, rd_done, wr_done, wr_err, req_drop
  );
endinterface

// File: rtl/efuse_seq_ctrl.sv
// efuse_seq_ctrl: eFuse read-all / program-one-bit timing sequencer.
// Define EFUSE_AUTOLOAD_EN to start a read-all one cycle after reset release.
module efuse_seq_ctrl #(
  parameter int NR = 64,
  parameter int NW = 64,
  parameter int CW = 8
) (
  input logic clk,
  input logic rst_n,
  efuse_seq_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD_SETUP, RD_STROBE, RD_HOLD, WR_SETUP, WR_STROBE, WR_HOLD} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, tsel, ld;
  logic [7:0] idx, idx_nxt, waddr;
  logic last, idle, auto_go, start_rd, start_wr, bad_wr, hold_done, last_byte, nxt_rd, nxt_wr;
`ifdef EFUSE_AUTOLOAD_EN
  logic auto_pend;
  assign auto_go = auto_pend;
`else
  assign auto_go = 1'b0;
`endif
  assign last      = cnt == '0;
  assign idle      = state == IDLE;
  assign start_rd  = idle && (bus.rd_start || auto_go);
  assign start_wr  = idle && !start_rd && bus.wr_req && int'(bus.wr_addr) < NW;
  assign bad_wr    = idle && !start_rd && bus.wr_req && int'(bus.wr_addr) >= NW;
  assign hold_done = state == RD_HOLD && last;
  assign last_byte = idx == 8'(NR - 1);
  assign idx_nxt   = hold_done ? (last_byte ? 8'd0 : idx + 8'd1) : idx;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = start_rd ? RD_SETUP : start_wr ? WR_SETUP : IDLE;
      RD_SETUP:  nxt = last ? RD_STROBE : RD_SETUP;
      RD_STROBE: nxt = last ? RD_HOLD : RD_STROBE;
      RD_HOLD:   nxt = last ? (last_byte ? IDLE : RD_SETUP) : RD_HOLD;
      WR_SETUP:  nxt = last ? WR_STROBE : WR_SETUP;
      WR_STROBE: nxt = last ? WR_HOLD : WR_STROBE;
      WR_HOLD:   nxt = last ? IDLE : WR_HOLD;
      default:   nxt = IDLE;
    endcase
  end
  assign nxt_rd = nxt inside {RD_SETUP, RD_STROBE, RD_HOLD};
  assign nxt_wr = nxt inside {WR_SETUP, WR_STROBE, WR_HOLD};
  // Timing inputs are sampled only when a state is entered; zero counts act as one cycle.
  assign tsel = nxt inside {RD_SETUP, WR_SETUP} ? bus.t_setup :
                nxt == RD_STROBE ? bus.t_rd : nxt == WR_STROBE ? bus.t_pgm : bus.t_hold;
  assign ld   = (nxt == IDLE || tsel == '0) ? '0 : tsel - CW'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      idx             <= '0;
      waddr           <= '0;
      bus.efuse_pgmen <= 1'b0;
      bus.efuse_rden  <= 1'b0;
      bus.efuse_aen   <= 1'b0;
      bus.efuse_addr  <= '0;
      bus.busy_read   <= 1'b0;
      bus.busy_write  <= 1'b0;
      bus.sh_we       <= 1'b0;
      bus.sh_addr     <= '0;
      bus.sh_wdata    <= '0;
      bus.rd_done     <= 1'b0;
      bus.wr_done     <= 1'b0;
      bus.wr_err      <= 1'b0;
      bus.req_drop    <= 1'b0;
`ifdef EFUSE_AUTOLOAD_EN
      auto_pend       <= 1'b1;
`endif
    end else begin
      state           <= nxt;
      cnt             <= (nxt != state) ? ld : (last ? cnt : cnt - CW'(1));
      idx             <= idx_nxt;
      waddr           <= start_wr ? bus.wr_addr : waddr;
      bus.efuse_pgmen <= nxt_wr;
      bus.efuse_rden  <= nxt_rd;
      bus.efuse_aen   <= nxt == RD_STROBE || nxt == WR_STROBE;
      bus.efuse_addr  <= nxt_rd ? idx_nxt : nxt_wr ? (start_wr ? bus.wr_addr : waddr) : 8'd0;
      bus.busy_read   <= nxt_rd;
      bus.busy_write  <= nxt_wr;
      bus.sh_we       <= hold_done;
      bus.sh_addr     <= hold_done ? idx : bus.sh_addr;
      bus.sh_wdata    <= hold_done ? bus.read_rdata : bus.sh_wdata;
      bus.rd_done     <= hold_done && last_byte;
      bus.wr_done     <= (state == WR_HOLD && last) || bad_wr;
      bus.wr_err      <= bad_wr;
      bus.req_drop    <= (!idle && (bus.rd_start || bus.wr_req)) ||
                         (start_rd && (bus.wr_req || (auto_go && bus.rd_start)));
`ifdef EFUSE_AUTOLOAD_EN
      auto_pend       <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_efuse_seq_ctrl.sv
// tb_efuse_seq_ctrl: scoreboard bench for efuse_seq_ctrl (NR=4) with a behavioural eFuse read port
module tb_efuse_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  efuse_seq_ctrl_if #(.CW(8)) bus ();
  efuse_seq_ctrl #(.NR(4), .NW(64), .CW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.read_rdata = 8'hA0 + bus.efuse_addr;
  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  int c_rden = 0, c_pgmen = 0, c_aen = 0, c_brd = 0, c_bwr = 0, c_drop = 0, c_wrdone = 0;
  logic [7:0] aen_addr = '0;
  logic [15:0] sh_q[$];
  logic [1:0] done_q[$];
  function automatic void check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction
  always @(negedge clk) begin
    logic [15:0] s;
    logic [1:0] d;
    c_rden  += int'(bus.efuse_rden);
    c_pgmen += int'(bus.efuse_pgmen);
    c_aen   += int'(bus.efuse_aen);
    c_brd   += int'(bus.busy_read);
    c_bwr   += int'(bus.busy_write);
    c_drop  += int'(bus.req_drop);
    c_wrdone += int'(bus.wr_done);
    if (bus.efuse_aen) aen_addr = bus.efuse_addr;
    if (bus.efuse_rden && bus.efuse_pgmen) check("rden_pgmen_excl", 1, 0);
    if (bus.busy_read && bus.busy_write) check("busy_excl", 1, 0);
    if (bus.sh_we) begin
      if (sh_q.size() == 0) check("sh_unexpected", 1, 0);
      else begin
        s = sh_q.pop_front();
        check("sh_addr", int'(bus.sh_addr), int'(s[15:8]));
        check("sh_wdata", int'(bus.sh_wdata), int'(s[7:0]));
      end
    end
    if (bus.rd_done || bus.wr_done) begin
      n_done++;
      if (done_q.size() == 0) check("done_unexpected", 1, 0);
      else begin
        d = done_q.pop_front();
        check("done_kind_err", int'({bus.wr_done, bus.wr_err}), int'(d));
      end
    end
  end
  task automatic wait_done(input int budget);
    int n0 = n_done;
    for (int i = 0; i < budget && n_done == n0; i++) @(negedge clk);
    if (n_done == n0) check("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask
  task automatic push_read();
    for (int i = 0; i < 4; i++) sh_q.push_back({8'(i), 8'(8'hA0 + i)});
    done_q.push_back(2'b00);
  endtask
  task automatic set_t(input int s, input int r, input int p, input int h);
    bus.t_setup = 8'(s); bus.t_rd = 8'(r); bus.t_pgm = 8'(p); bus.t_hold = 8'(h);
  endtask
  initial begin
    int b_rden, b_pgmen, b_aen, b_brd, b_bwr, b_drop, b_wrd;
    bus.rd_start = 1'b0; bus.wr_req = 1'b0; bus.wr_addr = '0;
    set_t(2, 3, 40, 1);
    repeat (3) @(negedge clk);
    check("rst_pgmen", int'(bus.efuse_pgmen), 0);
    check("rst_rden", int'(bus.efuse_rden), 0);
    check("rst_aen", int'(bus.efuse_aen), 0);
    check("rst_busy", int'({bus.busy_read, bus.busy_write}), 0);
    check("rst_done", int'({bus.rd_done, bus.wr_done, bus.wr_err, bus.sh_we, bus.req_drop}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // read-all, 2/3/1 timing
    {b_rden, b_aen, b_brd, b_drop} = {c_rden, c_aen, c_brd, c_drop};
    push_read();
    bus.rd_start = 1'b1; @(negedge clk); bus.rd_start = 1'b0;
    wait_done(100);
    check("rd_busy_cycles", c_brd - b_brd, 24);
    check("rd_rden_cycles", c_rden - b_rden, 24);
    check("rd_aen_cycles", c_aen - b_aen, 12);
    check("rd_no_drop", c_drop - b_drop, 0);
    // program bit 17, t_pgm=40
    {b_pgmen, b_aen, b_bwr} = {c_pgmen, c_aen, c_bwr};
    done_q.push_back(2'b10);
    bus.wr_addr = 8'd17; bus.wr_req = 1'b1; @(negedge clk); bus.wr_req = 1'b0;
    wait_done(100);
    check("wr_pgmen_cycles", c_pgmen - b_pgmen, 43);
    check("wr_busy_cycles", c_bwr - b_bwr, 43);
    check("wr_aen_cycles", c_aen - b_aen, 40);
    check("wr_aen_addr", int'(aen_addr), 17);
    // out-of-range program request
    {b_pgmen, b_aen, b_bwr} = {c_pgmen, c_aen, c_bwr};
    done_q.push_back(2'b11);
    bus.wr_addr = 8'd64; bus.wr_req = 1'b1; @(negedge clk); bus.wr_req = 1'b0;
    check("bad_wr_done_next", int'({bus.wr_done, bus.wr_err}), 3);
    wait_done(10);
    check("bad_pgmen", c_pgmen - b_pgmen, 0);
    check("bad_aen", c_aen - b_aen, 0);
    check("bad_busy_write", c_bwr - b_bwr, 0);
    // simultaneous rd_start and wr_req
    {b_pgmen, b_drop, b_brd} = {c_pgmen, c_drop, c_brd};
    push_read();
    bus.wr_addr = 8'd3; bus.rd_start = 1'b1; bus.wr_req = 1'b1; @(negedge clk);
    bus.rd_start = 1'b0; bus.wr_req = 1'b0;
    wait_done(100);
    check("both_drop", c_drop - b_drop, 1);
    check("both_no_pgm", c_pgmen - b_pgmen, 0);
    check("both_busy_read", c_brd - b_brd, 24);
    // wr_req in the middle of a read
    {b_pgmen, b_drop} = {c_pgmen, c_drop};
    push_read();
    bus.rd_start = 1'b1; @(negedge clk); bus.rd_start = 1'b0;
    repeat (5) @(negedge clk);
    bus.wr_req = 1'b1; @(negedge clk); bus.wr_req = 1'b0;
    wait_done(100);
    check("mid_drop", c_drop - b_drop, 1);
    check("mid_no_pgm", c_pgmen - b_pgmen, 0);
    // zero timing: one cycle per phase
    set_t(0, 0, 0, 0);
    {b_brd, b_aen} = {c_brd, c_aen};
    push_read();
    bus.rd_start = 1'b1; @(negedge clk); bus.rd_start = 1'b0;
    wait_done(100);
    check("zero_busy_cycles", c_brd - b_brd, 12);
    check("zero_aen_cycles", c_aen - b_aen, 4);
    // reset during WR_STROBE
    set_t(2, 3, 40, 1);
    b_wrd = c_wrdone;
    bus.wr_addr = 8'd5; bus.wr_req = 1'b1; @(negedge clk); bus.wr_req = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_aen", int'(bus.efuse_aen), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_pgmen", int'(bus.efuse_pgmen), 0);
    check("rst_mid_aen", int'(bus.efuse_aen), 0);
    check("rst_mid_busy", int'(bus.busy_write), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("rst_no_wr_done", c_wrdone - b_wrd, 0);
    check("sh_q_empty", sh_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
